// File: rtl/einsum_accum_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : einsum_pkg                                                  |
// | Shared types and constants for the einsum reduction stage: log-domain |
// | word limits, fold operator / FSM state enums and the LSE correction   |
// | table generator.                                                      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package einsum_pkg;

  localparam int              LOG_W   = 24;
  localparam logic [LOG_W-1:0] NEG_INF = 24'h800000;  // linear zero
  localparam logic [LOG_W-1:0] LOG_MAX = 24'h7FFFFF;
  localparam logic [LOG_W-1:0] LOG_MIN = 24'h800000;

  typedef enum logic [1:0] {
    PE_LSE = 2'b00,
    PE_LIN = 2'b01,
    PE_MAX = 2'b10
  } pe_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    OUT  = 2'b10
  } accum_state_e;

  // Raw pe_mode code to operator; the unused code 11 behaves as LSE.
  function automatic pe_mode_e to_mode(input logic [1:0] i_code);
    pe_mode_e v;
    case (i_code)
      2'b01:   v = PE_LIN;
      2'b10:   v = PE_MAX;
      default: v = PE_LSE;
    endcase
    return v;
  endfunction

  // LSE correction entry: round(log2(1 + 2^(-idx/8)) * 2^frac_bits).
  // Only ever called with elaboration-time constant arguments.
  function automatic logic [LOG_W-1:0] lse_lut_entry(input int frac_bits, input int idx);
    real r;
    if (idx == 0) begin
      return LOG_W'(1) << frac_bits;
    end
    r = ($ln(1.0 + 2.0 ** (-real'(idx) / 8.0)) / $ln(2.0)) * (2.0 ** frac_bits);
    return LOG_W'($rtoi(r + 0.5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/einsum_accum_lse.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : lse_add                                                     |
// | Combinational log-sum-exp fold of two base-2 log words using a        |
// | 64-entry correction table; flags positive saturation.                 |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module lse_add
  import einsum_pkg::*;
#(
  parameter int FRAC_BITS = 10
) (
  input  logic [LOG_W-1:0] i_a,
  input  logic [LOG_W-1:0] i_b,
  output logic [LOG_W-1:0] o_sum,
  output logic             o_sat
);

  logic [LOG_W-1:0] w_lut [64];

  // Correction table, one constant entry per index.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_lut
      assign w_lut[gi] = lse_lut_entry(FRAC_BITS, gi);
    end
  endgenerate

  logic [LOG_W:0]   w_diff;
  logic [LOG_W:0]   w_absd;
  logic [LOG_W:0]   w_shift;
  logic [LOG_W:0]   w_sum;
  logic [LOG_W-1:0] w_m;
  logic [5:0]       w_idx;
  logic             w_a_ge;
  logic             w_far;

  // Larger operand plus table correction indexed by the operand distance.
  always_comb begin
    w_diff  = {i_a[LOG_W-1], i_a} - {i_b[LOG_W-1], i_b};
    w_a_ge  = ~w_diff[LOG_W];
    w_m     = w_a_ge ? i_a : i_b;
    w_absd  = w_a_ge ? w_diff : (~w_diff + 1'b1);
    w_far   = (w_absd >= ((LOG_W+1)'(8) << FRAC_BITS));
    w_shift = w_absd >> (FRAC_BITS - 3);
    w_idx   = w_shift[5:0];
    w_sum   = {w_m[LOG_W-1], w_m} + {1'b0, w_lut[w_idx]};
    o_sum   = w_m;
    o_sat   = 1'b0;
    if (i_a == NEG_INF) begin
      o_sum = i_b;
    end else if (i_b == NEG_INF) begin
      o_sum = i_a;
    end else if (!w_far) begin
      // The correction is positive, so only the upper bound can be crossed.
      if (!w_sum[LOG_W] && w_sum[LOG_W-1]) begin
        o_sum = LOG_MAX;
        o_sat = 1'b1;
      end else begin
        o_sum = w_sum[LOG_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/einsum_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : einsum_accum                                                |
// | Folds each reduction group of log-domain products (LSE, linear add    |
// | or max) into one result and hands it downstream via valid/ready.      |
// | Option  : EINSUM_ACCUM_SAT_FLAG_EN adds the sticky out_sat port.      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module einsum_accum
  import einsum_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int MAX_LEN    = 256,
  parameter int CNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [1:0]            pe_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
`ifdef EINSUM_ACCUM_SAT_FLAG_EN
  output logic                  out_sat,
`endif
  output logic [CNT_WIDTH-1:0]  out_len
);

  accum_state_e          r_state;
  pe_mode_e              r_mode;
  logic [LOG_W-1:0]      r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]  r_out_len;
  logic                  r_out_valid;

  pe_mode_e              w_mode;
  logic [LOG_W-1:0]      w_base;
  logic [LOG_W-1:0]      w_beat;
  logic [LOG_W-1:0]      w_fold;
  logic                  w_fold_sat;
  logic [LOG_W:0]        w_lin_sum;
  logic [LOG_W-1:0]      w_lse_sum;
  logic                  w_lse_sat;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  w_close;
  logic                  w_hs;

  assign in_ready  = !rst && (r_state != OUT);
  assign w_hs      = in_valid && in_ready;
  assign w_beat    = in_data[LOG_W-1:0];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_len   = r_out_len;

  lse_add #(
    .FRAC_BITS (FRAC_BITS)
  ) u_lse (
    .i_a   (w_base),
    .i_b   (w_beat),
    .o_sum (w_lse_sum),
    .o_sat (w_lse_sat)
  );

  // Operator and running value; the first beat folds against the identity.
  always_comb begin
    w_mode     = (r_state == IDLE) ? to_mode(pe_mode) : r_mode;
    w_base     = r_acc;
    if (r_state == IDLE) begin
      w_base = (w_mode == PE_LIN) ? '0 : NEG_INF;
    end
    w_lin_sum  = {w_base[LOG_W-1], w_base} + {w_beat[LOG_W-1], w_beat};
    w_fold     = w_lse_sum;
    w_fold_sat = w_lse_sat;
    case (w_mode)
      PE_LIN: begin
        if (w_lin_sum[LOG_W] != w_lin_sum[LOG_W-1]) begin
          w_fold     = w_lin_sum[LOG_W] ? LOG_MIN : LOG_MAX;
          w_fold_sat = 1'b1;
        end else begin
          w_fold     = w_lin_sum[LOG_W-1:0];
          w_fold_sat = 1'b0;
        end
      end
      PE_MAX: begin
        w_fold     = ($signed(w_beat) > $signed(w_base)) ? w_beat : w_base;
        w_fold_sat = 1'b0;
      end
      default: begin
        w_fold     = w_lse_sum;
        w_fold_sat = w_lse_sat;
      end
    endcase
    w_cnt_next = (r_state == IDLE) ? CNT_WIDTH'(1) : (r_cnt + CNT_WIDTH'(1));
    w_close    = in_last || (w_cnt_next == CNT_WIDTH'(MAX_LEN));
  end

  // Group FSM: accumulate beats, park the result in OUT until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= PE_LSE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_len   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_hs) begin
            if (r_state == IDLE) begin
              r_mode <= w_mode;
            end
            if (w_close) begin
              r_out_data  <= WORD_WIDTH'(w_fold);
              r_out_len   <= w_cnt_next;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= OUT;
            end else begin
              r_acc   <= w_fold;
              r_cnt   <= w_cnt_next;
              r_state <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EINSUM_ACCUM_SAT_FLAG_EN
  logic r_grp_sat;
  logic r_out_sat;
  logic w_grp_sat;
  logic w_unused;

  assign w_grp_sat = ((r_state == ACC) ? r_grp_sat : 1'b0) | w_fold_sat;
  assign out_sat   = r_out_sat;
  assign w_unused  = ^in_data[WORD_WIDTH-1:LOG_W];

  // Sticky saturation flag, captured with the result and dropped when the next group opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp_sat <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (w_hs) begin
      r_grp_sat <= w_close ? 1'b0 : w_grp_sat;
      if (w_close) begin
        r_out_sat <= w_grp_sat;
      end else if (r_state == IDLE) begin
        r_out_sat <= 1'b0;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{in_data[WORD_WIDTH-1:LOG_W], w_fold_sat};
`endif

endmodule
`default_nettype wire
